// File: rtl/uart_rx_to_mem_pkg.sv
// Shared definitions for the matrix-multiplier UART link: FSM/LED encodings and
// default baud/matrix parameters, kept in one place so RX and TX cannot diverge.
package uart_rx_to_mem_pkg;

  localparam int DEF_CLKS_PER_BIT = 10416;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_MAT_N        = 2;

  typedef logic [4:0] led_state_t;

  // One-hot bit-engine states double as the board LED pattern.
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_START = 5'b00010;
  localparam logic [4:0] ST_DATA  = 5'b00100;
  localparam logic [4:0] ST_STOP  = 5'b01000;
  localparam logic [4:0] ST_DONE  = 5'b10000;
  localparam logic [4:0] ST_WRITE = 5'b01000;

  localparam logic [1:0] CTRL_LOAD  = 2'd0;
  localparam logic [1:0] CTRL_WRITE = 2'd1;
  localparam logic [1:0] CTRL_DONE  = 2'd2;

  function automatic int words_to_load(input int mat_n);
    return 2 * mat_n * mat_n;
  endfunction

endpackage

// File: rtl/uart_rx_to_mem_if.sv
// Write port into the operand memory, driven by the UART receive path.
interface uart_rx_to_mem_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART bit engine: input synchroniser plus IDLE/START/DATA/STOP sampling.
// Reports a good byte or a framing error combinationally in the stop-sample cycle.
module uart_rx_core
  import uart_rx_to_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  input  logic              enable,
  input  logic              abort,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err_pulse,
  output logic              busy,
  output led_state_t        state_led
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TIMER_W-1:0] BIT_END  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_END = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_W - 1);

  logic               rx_meta;
  logic               rx_sync;
  led_state_t         state;
  logic [TIMER_W-1:0] timer;
  logic [BIT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  shift_reg;
  logic               bit_tick;
  logic               half_tick;

  // Idle-high line, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
    end
  end

  assign bit_tick  = (timer == BIT_END);
  assign half_tick = (timer == HALF_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (enable && !rx_sync) state <= ST_START;
        end
        ST_START: begin
          if (half_tick) begin
            timer <= '0;
            state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            timer     <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_W-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              state   <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_STOP: begin
          // Return straight to IDLE; a line still low simply re-arms START.
          if (bit_tick) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign byte_valid      = (state == ST_STOP) && bit_tick && rx_sync  && !abort;
  assign frame_err_pulse = (state == ST_STOP) && bit_tick && !rx_sync && !abort;
  assign rx_byte         = shift_reg;
  assign busy            = (state != ST_IDLE);
  assign state_led       = state;

endmodule

// File: rtl/uart_rx_to_mem.sv
// UART receive path into the operand memory: A then B, row-major, from address 0.
// Owns load_en handling, the single-cycle WRITE, the address counter and DONE.
module uart_rx_to_mem
  import uart_rx_to_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAT_N        = DEF_MAT_N,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  input  logic              load_en,
  uart_rx_to_mem_if.master  mem,
  output logic [ADDR_W:0]   values_rcvd_count,
  output logic              load_done,
  output logic              frame_err,
  output logic              rx_status,
  output logic [4:0]        state_LED
);

  localparam int            WORDS     = words_to_load(MAT_N);
  localparam logic [ADDR_W:0] WORDS_CNT = (ADDR_W + 1)'(WORDS);

  logic [1:0]        ctrl;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              frame_err_q;

  logic              core_enable;
  logic [DATA_W-1:0] core_byte;
  logic              core_valid;
  logic              core_frame_err;
  logic              core_busy;
  led_state_t        core_led;

  assign core_enable = load_en && (ctrl == CTRL_LOAD) && (count < WORDS_CNT);
  assign count_next  = count + 1'b1;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_core (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .enable          (core_enable),
    .abort           (!load_en),
    .rx_byte         (core_byte),
    .byte_valid      (core_valid),
    .frame_err_pulse (core_frame_err),
    .busy            (core_busy),
    .state_led       (core_led)
  );

  // Dropping load_en wipes progress so the next frame lands at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl        <= CTRL_LOAD;
      count       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      frame_err_q <= 1'b0;
    end else if (!load_en) begin
      ctrl        <= CTRL_LOAD;
      count       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      if (core_frame_err) frame_err_q <= 1'b1;
      unique case (ctrl)
        CTRL_LOAD: begin
          if (core_valid) begin
            ctrl    <= CTRL_WRITE;
            addr_q  <= count[ADDR_W-1:0];
            wdata_q <= core_byte;
          end
        end
        CTRL_WRITE: begin
          count <= count_next;
          ctrl  <= (count_next == WORDS_CNT) ? CTRL_DONE : CTRL_LOAD;
        end
        CTRL_DONE: begin
          ctrl <= CTRL_DONE;
        end
        default: begin
          ctrl <= CTRL_LOAD;
        end
      endcase
    end
  end

  always_comb begin
    state_LED = core_led;
    unique case (ctrl)
      CTRL_WRITE: state_LED = ST_WRITE;
      CTRL_DONE:  state_LED = ST_DONE;
      default:    state_LED = core_led;
    endcase
  end

  assign mem.we            = (ctrl == CTRL_WRITE);
  assign mem.addr          = addr_q;
  assign mem.wdata         = wdata_q;
  assign values_rcvd_count = count;
  assign load_done         = (ctrl == CTRL_DONE);
  assign frame_err         = frame_err_q;
  assign rx_status         = core_busy || (ctrl == CTRL_WRITE);

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Scoreboard bench for uart_rx_to_mem: expected writes are queued as frames are
// sent and popped by a write monitor; scenario tasks check status outputs inline.
module tb_uart_rx_to_mem;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_data;
  logic       load_en;
  logic [3:0] values_rcvd_count;
  logic       load_done;
  logic       frame_err;
  logic       rx_status;
  logic [4:0] state_LED;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_count;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_to_mem_if #(.ADDR_W(3), .DATA_W(8)) mem_bus ();

  uart_rx_to_mem #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8),
    .MAT_N        (2),
    .ADDR_W       (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .load_en           (load_en),
    .mem               (mem_bus),
    .values_rcvd_count (values_rcvd_count),
    .load_done         (load_done),
    .frame_err         (frame_err),
    .rx_status         (rx_status),
    .state_LED         (state_LED)
  );

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    logic [10:0] exp_w;
    if (mem_bus.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%02h, expected no write",
                 mem_bus.addr, mem_bus.wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_bus.addr, mem_bus.wdata} !== exp_w) begin
          errors++;
          $display("[TB] FAIL write_data: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h",
                   mem_bus.addr, mem_bus.wdata, exp_w[10:8], exp_w[7:0]);
        end
      end
      checks++;
      if (state_LED !== 5'b01000) begin
        errors++;
        $display("[TB] FAIL write_led: got %b, expected 01000", state_LED);
      end
    end
  end

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_data = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back({exp_count[2:0], b});
    exp_count = exp_count + 1'b1;
    send_frame(b, 1'b1);
  endtask

  task automatic restart_load();
    load_en = 1'b0;
    @(negedge clk);
    checks++;
    if (values_rcvd_count !== 4'd0 || load_done !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_en_clear: got count=%0d done=%b ferr=%b, expected 0 0 0",
               values_rcvd_count, load_done, frame_err);
    end
    load_en   = 1'b1;
    exp_count = 4'd0;
    idle(4);
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_pending: got %0d writes outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    load_en = 1'b0;
    rx_data = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_bus.we !== 1'b0 || mem_bus.addr !== 3'd0 || mem_bus.wdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mem: got we=%b addr=%0d data=0x%02h, expected 0 0 0x00",
               mem_bus.we, mem_bus.addr, mem_bus.wdata);
    end
    checks++;
    if (values_rcvd_count !== 4'd0 || load_done !== 1'b0 || frame_err !== 1'b0 ||
        rx_status !== 1'b0 || state_LED !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_status: got count=%0d done=%b ferr=%b busy=%b led=%b, expected 0 0 0 0 00001",
               values_rcvd_count, load_done, frame_err, rx_status, state_LED);
    end
    rst       = 1'b0;
    load_en   = 1'b1;
    exp_count = 4'd0;
    idle(5);
  endtask

  task automatic test_load_matrices();
    for (int i = 1; i <= 8; i++) send_good(8'(i));
    idle(5);
    checks++;
    if (load_done !== 1'b1 || values_rcvd_count !== 4'd8 || frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: got done=%b count=%0d ferr=%b, expected 1 8 0",
               load_done, values_rcvd_count, frame_err);
    end
    checks++;
    if (state_LED !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL done_led: got %b, expected 10000", state_LED);
    end
    check_drained("load");
  endtask

  task automatic test_glitch();
    restart_load();
    rx_data = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state_LED !== 5'b00010 || rx_status !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_start: got led=%b busy=%b, expected 00010 1", state_LED, rx_status);
    end
    @(negedge clk);
    idle(30);
    checks++;
    if (state_LED !== 5'b00001 || rx_status !== 1'b0 || values_rcvd_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: got led=%b busy=%b count=%0d, expected 00001 0 0",
               state_LED, rx_status, values_rcvd_count);
    end
    check_drained("glitch");
  endtask

  task automatic test_bad_stop();
    send_frame(8'hA5, 1'b0);
    idle(40);
    checks++;
    if (frame_err !== 1'b1 || values_rcvd_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL bad_stop: got ferr=%b count=%0d, expected 1 0", frame_err, values_rcvd_count);
    end
    check_drained("bad_stop");
    send_good(8'h3C);
    idle(5);
    checks++;
    if (values_rcvd_count !== 4'd1 || frame_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_bad_stop: got count=%0d ferr=%b, expected 1 1", values_rcvd_count, frame_err);
    end
    check_drained("after_bad_stop");
  endtask

  task automatic test_abort_and_extra();
    restart_load();
    send_good(8'h11);
    send_good(8'h22);
    rx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_data = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (state_LED !== 5'b00100) begin
      errors++;
      $display("[TB] FAIL abort_in_data: got led=%b, expected 00100", state_LED);
    end
    load_en = 1'b0;
    @(negedge clk);
    checks++;
    if (values_rcvd_count !== 4'd0 || state_LED !== 5'b00001 || rx_status !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_clear: got count=%0d led=%b busy=%b, expected 0 00001 0",
               values_rcvd_count, state_LED, rx_status);
    end
    idle(10);
    load_en   = 1'b1;
    exp_count = 4'd0;
    idle(30);
    check_drained("abort");
    for (int i = 0; i < 8; i++) send_good(8'h40 + 8'(i));
    idle(5);
    checks++;
    if (load_done !== 1'b1 || values_rcvd_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL reload_done: got done=%b count=%0d, expected 1 8", load_done, values_rcvd_count);
    end
    send_frame(8'h99, 1'b1);
    idle(10);
    checks++;
    if (load_done !== 1'b1 || values_rcvd_count !== 4'd8 || state_LED !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL extra_byte: got done=%b count=%0d led=%b, expected 1 8 10000",
               load_done, values_rcvd_count, state_LED);
    end
    check_drained("reload");
  endtask

  task automatic test_back_to_back();
    restart_load();
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h80);
    send_good(8'h01);
    idle(5);
    checks++;
    if (values_rcvd_count !== 4'd4 || frame_err !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pattern_status: got count=%0d ferr=%b done=%b, expected 4 0 0",
               values_rcvd_count, frame_err, load_done);
    end
    check_drained("pattern");
  endtask

  task automatic test_reset_mid();
    rx_data = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_bus.we !== 1'b0 || mem_bus.addr !== 3'd0 || mem_bus.wdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset_mem: got we=%b addr=%0d data=0x%02h, expected 0 0 0x00",
               mem_bus.we, mem_bus.addr, mem_bus.wdata);
    end
    checks++;
    if (values_rcvd_count !== 4'd0 || load_done !== 1'b0 || rx_status !== 1'b0 ||
        state_LED !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL mid_reset_status: got count=%0d done=%b busy=%b led=%b, expected 0 0 0 00001",
               values_rcvd_count, load_done, rx_status, state_LED);
    end
    @(negedge clk);
    rx_data = 1'b1;
    rst     = 1'b0;
    idle(5);
  endtask

  initial begin
    rst     = 1'b1;
    load_en = 1'b0;
    rx_data = 1'b1;
    @(negedge clk);
    test_reset();
    test_load_matrices();
    test_glitch();
    test_bad_stop();
    test_abort_and_extra();
    test_back_to_back();
    test_reset_mid();
    check_drained("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
